// File: rtl/hb_rx_uart.sv
// 8N1 UART receiver: two-flop pin synchroniser, false-start rejection, mid-bit sampling,
// one strobe per good byte, framing-error pulse and break level.
module hb_rx_uart #(
    parameter int CLOCKS_PER_BAUD = 868,
    parameter int BAUD_BITS       = 24
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_uart_rx,
    output logic       o_rx_stb,
    output logic [7:0] o_rx_byte,
    output logic       o_frame_err,
    output logic       o_break
);

    localparam logic [BAUD_BITS-1:0] HALF = BAUD_BITS'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [BAUD_BITS-1:0] FULL = BAUD_BITS'(CLOCKS_PER_BAUD - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT} state_t;

    state_t               state, state_d;
    logic                 rx_meta, rx;
    logic [BAUD_BITS-1:0] baud_cnt;
    logic [2:0]           bit_cnt;
    logic [7:0]           shreg;
    logic                 sample;
    logic                 load_half, load_full, shift_bit, clr_bits;
    logic                 stb_d, ferr_d, brk_set, brk_clr;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta <= 1'b1;
            rx      <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx      <= rx_meta;
        end
    end

    // A load of N lands the sample point on the cycle the counter reaches zero.
    assign sample = (baud_cnt == '0);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= S_IDLE;
        else            state <= state_d;
    end

    always_comb begin
        state_d   = state;
        load_half = 1'b0;
        load_full = 1'b0;
        shift_bit = 1'b0;
        clr_bits  = 1'b0;
        stb_d     = 1'b0;
        ferr_d    = 1'b0;
        brk_set   = 1'b0;
        brk_clr   = 1'b0;
        case (state)
            S_IDLE: if (!rx) begin
                load_half = 1'b1;
                state_d   = S_START;
            end
            S_START: if (sample) begin
                if (rx) begin
                    state_d = S_IDLE;
                end else begin
                    load_full = 1'b1;
                    clr_bits  = 1'b1;
                    state_d   = S_DATA;
                end
            end
            S_DATA: if (sample) begin
                shift_bit = 1'b1;
                load_full = 1'b1;
                if (bit_cnt == 3'd7) state_d = S_STOP;
            end
            S_STOP: if (sample) begin
                if (rx) begin
                    stb_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ferr_d  = 1'b1;
                    brk_set = (shreg == 8'h00);
                    state_d = S_WAIT;
                end
            end
            // Hold off after a bad stop bit until the line returns to idle.
            S_WAIT: if (rx) begin
                brk_clr = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            baud_cnt    <= '0;
            bit_cnt     <= 3'd0;
            shreg       <= 8'h00;
            o_rx_byte   <= 8'h00;
            o_rx_stb    <= 1'b0;
            o_frame_err <= 1'b0;
            o_break     <= 1'b0;
        end else begin
            if (load_half)           baud_cnt <= HALF;
            else if (load_full)      baud_cnt <= FULL;
            else if (baud_cnt != '0) baud_cnt <= baud_cnt - BAUD_BITS'(1);

            if (clr_bits)       bit_cnt <= 3'd0;
            else if (shift_bit) bit_cnt <= bit_cnt + 3'd1;

            if (shift_bit) shreg <= {rx, shreg[7:1]};
            if (stb_d)     o_rx_byte <= shreg;

            o_rx_stb    <= stb_d;
            o_frame_err <= ferr_d;
            if (brk_set)      o_break <= 1'b1;
            else if (brk_clr) o_break <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hb_rx_uart.sv
// Scoreboard bench for hb_rx_uart: two instances (16 and 5 clocks per bit), directed frames,
// monitors compare every strobe / framing error against queued expectations including timing.
module tb_hb_rx_uart;

    localparam int CPB_A = 16;
    localparam int CPB_B = 5;
    // Pin driven just after edge k -> output visible after edge k + 4 + HALF + 9*CPB.
    localparam int LAT_A = 155;
    localparam int LAT_B = 50;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        bit         brk;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rx_b;
    logic       stb_a, ferr_a, brk_a, stb_b, ferr_b, brk_b;
    logic [7:0] byte_a, byte_b;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [7:0] lg_a = 8'h00;
    logic [7:0] lg_b = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hb_rx_uart #(.CLOCKS_PER_BAUD(CPB_A), .BAUD_BITS(24)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_uart_rx(rx_a),
        .o_rx_stb(stb_a), .o_rx_byte(byte_a), .o_frame_err(ferr_a), .o_break(brk_a)
    );

    hb_rx_uart #(.CLOCKS_PER_BAUD(CPB_B), .BAUD_BITS(24)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_uart_rx(rx_b),
        .o_rx_stb(stb_b), .o_rx_byte(byte_b), .o_frame_err(ferr_b), .o_break(brk_b)
    );

    task automatic chk(input string name, input int act, input int want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Must be entered right at a posedge; returns at a posedge so frames chain back-to-back.
    task automatic send(input bit b, input logic [7:0] d, input bit stop, input int nb);
        logic [9:0] frame;
        int         cpb;
        exp_t       e;
        frame = {stop, d, 1'b0};
        cpb   = b ? CPB_B : CPB_A;
        for (int i = 0; i < nb; i++) begin
            #1;
            if (b) rx_b = frame[i];
            else   rx_a = frame[i];
            if (i == 0 && nb == 10) begin
                e.ferr = !stop;
                e.brk  = !stop && (d == 8'h00);
                e.data = stop ? d : (b ? lg_b : lg_a);
                e.cyc  = cyc + (b ? LAT_B : LAT_A);
                if (stop) begin
                    if (b) lg_b = d;
                    else   lg_a = d;
                end
                if (b) q_b.push_back(e);
                else   q_a.push_back(e);
            end
            repeat (cpb) @(posedge clk);
        end
    endtask

    always @(negedge clk) if (stb_a || ferr_a) begin
        exp_t e;
        chk("a_stb_and_err", int'(stb_a & ferr_a), 0);
        if (q_a.size() == 0) begin
            chk("a_unexpected_output", 1, 0);
        end else begin
            e = q_a.pop_front();
            chk("a_kind_ferr", int'(ferr_a), int'(e.ferr));
            chk("a_cycle", cyc, e.cyc);
            chk("a_byte", int'(byte_a), int'(e.data));
            chk("a_break", int'(brk_a), int'(e.brk));
        end
    end

    always @(negedge clk) if (stb_b || ferr_b) begin
        exp_t e;
        chk("b_stb_and_err", int'(stb_b & ferr_b), 0);
        if (q_b.size() == 0) begin
            chk("b_unexpected_output", 1, 0);
        end else begin
            e = q_b.pop_front();
            chk("b_kind_ferr", int'(ferr_b), int'(e.ferr));
            chk("b_cycle", cyc, e.cyc);
            chk("b_byte", int'(byte_b), int'(e.data));
            chk("b_break", int'(brk_b), int'(e.brk));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_stb", int'(stb_a), 0);
        chk("rst_a_byte", int'(byte_a), 0);
        chk("rst_a_ferr", int'(ferr_a), 0);
        chk("rst_a_brk", int'(brk_a), 0);
        chk("rst_b_stb", int'(stb_b), 0);
        chk("rst_b_byte", int'(byte_b), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // good byte
        send(0, 8'h55, 1, 10);
        repeat (20) @(posedge clk);

        // false start, then a good byte
        #1 rx_a = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx_a = 1'b1;
        repeat (30) @(posedge clk);
        send(0, 8'h3C, 1, 10);
        repeat (10) @(posedge clk);

        // framing error with non-zero data
        send(0, 8'hA3, 0, 10);
        #1 rx_a = 1'b1;
        repeat (30) @(posedge clk);

        // break: line low 20 bit times
        send(0, 8'h00, 0, 10);
        repeat (10 * CPB_A) @(posedge clk);
        #1 rx_a = 1'b1;
        r = cyc;
        repeat (3) @(negedge clk);
        chk("break_held", int'(brk_a), 1);
        chk("break_hold_cycle", cyc, r + 2);
        @(negedge clk);
        chk("break_cleared", int'(brk_a), 0);
        repeat (20) @(posedge clk);
        send(0, 8'h41, 1, 10);
        repeat (10) @(posedge clk);

        // back-to-back frames, 160 clocks apart
        send(0, 8'h00, 1, 10);
        send(0, 8'hFF, 1, 10);
        send(0, 8'h7E, 1, 10);
        repeat (20) @(posedge clk);

        // reset during data bit 4 on the 16-clock instance
        send(0, 8'h81, 1, 5);
        #1 rx_a = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_a_stb", int'(stb_a), 0);
        chk("midrst_a_byte", int'(byte_a), 0);
        chk("midrst_a_ferr", int'(ferr_a), 0);
        chk("midrst_a_brk", int'(brk_a), 0);
        lg_a = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rx_a  = 1'b1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        send(0, 8'h81, 1, 10);
        repeat (10) @(posedge clk);

        // odd bit period: plain frame, then the reset sequence
        send(1, 8'hC3, 1, 10);
        repeat (10) @(posedge clk);
        send(1, 8'h81, 1, 5);
        #1 rx_b = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_b_stb", int'(stb_b), 0);
        chk("midrst_b_byte", int'(byte_b), 0);
        chk("midrst_b_ferr", int'(ferr_b), 0);
        lg_b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rx_b  = 1'b1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        send(1, 8'h81, 1, 10);
        repeat (40) @(posedge clk);

        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
